// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - single-port memory arbiter between a host access buffer and a video fetch stream
// Host accesses are buffered one deep and may be deferred by video for at most HOST_MAX_WAIT cycles.
module vga_mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 32,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ready_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_ack_o,
  output logic              vid_rvalid_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

  logic              pend_q, pend_d;
  logic              pend_we_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_wdata_q;
  logic [3:0]        wait_q, wait_d;

  logic              host_gnt;
  logic              vid_gnt;
  logic              host_accept;

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Read tags: stage 1 travels with the command, stage 2 lines up with mem_rdata_i.
  logic              rd1_host_q, rd1_vid_q;
  logic              rd2_host_q, rd2_vid_q;
  logic [DATA_W-1:0] host_hold_q, vid_hold_q;

  always_comb begin
    host_gnt    = pend_q && (!vid_req_i || (wait_q == MAX_WAIT));
    vid_gnt     = vid_req_i && !host_gnt;
    host_accept = host_req_i && !pend_q;

    pend_d = pend_q;
    if (host_gnt) begin
      pend_d = 1'b0;
    end
    if (host_accept) begin
      pend_d = 1'b1;
    end

    wait_d = wait_q;
    if (!pend_q || host_gnt) begin
      wait_d = 4'd0;
    end else if (wait_q != MAX_WAIT) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      wait_q       <= 4'd0;
    end else begin
      pend_q <= pend_d;
      wait_q <= wait_d;
      if (host_accept) begin
        pend_we_q    <= host_we_i;
        pend_addr_q  <= host_addr_i;
        pend_wdata_q <= host_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd1_host_q  <= 1'b0;
      rd1_vid_q   <= 1'b0;
      rd2_host_q  <= 1'b0;
      rd2_vid_q   <= 1'b0;
    end else begin
      mem_en_q   <= host_gnt || vid_gnt;
      mem_we_q   <= host_gnt && pend_we_q;
      rd1_host_q <= host_gnt && !pend_we_q;
      rd1_vid_q  <= vid_gnt;
      rd2_host_q <= rd1_host_q;
      rd2_vid_q  <= rd1_vid_q;
      if (host_gnt) begin
        mem_addr_q  <= pend_addr_q;
        mem_wdata_q <= pend_wdata_q;
      end else if (vid_gnt) begin
        mem_addr_q  <= vid_addr_i;
      end
    end
  end

  // Read data is passed through in its strobe cycle and held afterwards.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      host_hold_q <= '0;
      vid_hold_q  <= '0;
    end else begin
      if (rd2_host_q) begin
        host_hold_q <= mem_rdata_i;
      end
      if (rd2_vid_q) begin
        vid_hold_q <= mem_rdata_i;
      end
    end
  end

  assign host_ready_o  = !pend_q;
  assign vid_ack_o     = vid_gnt;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign host_rvalid_o = rd2_host_q;
  assign vid_rvalid_o  = rd2_vid_q;
  assign host_rdata_o  = rd2_host_q ? mem_rdata_i : host_hold_q;
  assign vid_rdata_o   = rd2_vid_q ? mem_rdata_i : vid_hold_q;

endmodule
